// File: rtl/psum_collector.sv
// Collects psum words from the bottom of a MAC column into a first-word-fall-through FIFO
// and streams them out in ROWS-beat bursts, with registered backpressure to the MAC chain.
module psum_collector #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ROWS       = 4,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DATA_WIDTH-1:0]         psum_in,
    input  logic                          psum_in_vld,
    output logic                          mac_read_stall,
    output logic [DATA_WIDTH-1:0]         m_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic                          m_last,
    output logic [$clog2(ROWS)-1:0]       m_idx,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned IW = $clog2(ROWS);
    localparam int unsigned CW = PW + 1;

    localparam logic [CW-1:0] STALL_LVL = CW'(FIFO_DEPTH - 1);
    localparam logic [IW-1:0] LAST_BEAT = IW'(ROWS - 1);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [IW-1:0] beat_q, beat_d;
    logic          stall_q, stall_d;

    logic push;
    logic pop;

    // A stalled MAC holds its word on psum_in; gating on the stall flop avoids double writes.
    assign push = rst_n && psum_in_vld && !stall_q;
    assign pop  = m_valid && m_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        beat_d   = beat_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
            beat_d   = (beat_q == LAST_BEAT) ? '0 : beat_q + IW'(1);
        end
        // One slot of headroom covers the cycle the registered stall takes to reach the MAC.
        stall_d = (count_d >= STALL_LVL);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            beat_q   <= '0;
            stall_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            beat_q   <= beat_d;
            stall_q  <= stall_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= psum_in;
        end
    end

    assign m_valid        = (count_q != '0);
    assign m_data         = mem[rd_ptr_q];
    assign m_idx          = beat_q;
    assign m_last         = m_valid && (beat_q == LAST_BEAT);
    assign count          = count_q;
    assign mac_read_stall = stall_q;

endmodule

// File: tb/tb_psum_collector.sv
// Self-checking bench for psum_collector: directed vectors and sequences plus a queue-based
// reference model compared against the outputs on every falling edge.
module tb_psum_collector;

    localparam int DW    = 8;
    localparam int ROWS  = 4;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] psum_in;
    logic          psum_in_vld;
    logic          mac_read_stall;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_last;
    logic [1:0]    m_idx;
    logic [3:0]    count;

    always #5 clk = ~clk;

    psum_collector #(
        .DATA_WIDTH (DW),
        .ROWS       (ROWS),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .psum_in        (psum_in),
        .psum_in_vld    (psum_in_vld),
        .mac_read_stall (mac_read_stall),
        .m_data         (m_data),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_last         (m_last),
        .m_idx          (m_idx),
        .count          (count)
    );

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at t=%0t", name, got, want, $time);
        end
    endtask

    // Reference model: a plain queue of words, a beat number and the stall rule.
    logic [DW-1:0] mq[$];
    int            mbeat = 0;
    bit            mstall = 1'b0;
    bit            m_do_pop, m_do_push;

    always @(posedge clk) begin
        if (!rst_n) begin
            mq.delete();
            mbeat  = 0;
            mstall = 1'b0;
        end else begin
            m_do_pop  = (mq.size() != 0) && m_ready;
            m_do_push = psum_in_vld && !mstall;
            if (m_do_pop) begin
                void'(mq.pop_front());
                mbeat = (mbeat + 1) % ROWS;
            end
            if (m_do_push) mq.push_back(psum_in);
            mstall = (mq.size() >= DEPTH - 1);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("mdl_valid", 32'(m_valid), 32'(mq.size() != 0));
            check("mdl_count", 32'(count), mq.size());
            check("mdl_stall", 32'(mac_read_stall), 32'(mstall));
            check("mdl_idx", 32'(m_idx), mbeat);
            check("mdl_last", 32'(m_last), 32'(mq.size() != 0 && mbeat == ROWS - 1));
            if (mq.size() != 0) check("mdl_data", 32'(m_data), 32'(mq[0]));
            check("count_bound", 32'(count <= 4'(DEPTH - 1)), 32'd1);
        end
    end

    task automatic step(input logic v, input logic [DW-1:0] d, input logic r);
        psum_in_vld = v;
        psum_in     = d;
        m_ready     = r;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(1'b0, 8'h00, 1'b0);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic          vld;
        logic [DW-1:0] data;
        logic          rdy;
        logic          e_valid;
        logic [DW-1:0] e_data;
        logic          e_last;
        logic [1:0]    e_idx;
        logic [3:0]    e_count;
    } vec_t;

    vec_t          tbl[6];
    logic [DW-1:0] got[$];
    logic [DW-1:0] words[20];
    int            v, acc, sent, pops, n77;
    bit            take, vb, rb, done;

    initial begin
        tbl[0] = '{1'b1, 8'h11, 1'b1, 1'b1, 8'h11, 1'b0, 2'd0, 4'd1};
        tbl[1] = '{1'b1, 8'h22, 1'b1, 1'b1, 8'h22, 1'b0, 2'd1, 4'd1};
        tbl[2] = '{1'b1, 8'h33, 1'b1, 1'b1, 8'h33, 1'b0, 2'd2, 4'd1};
        tbl[3] = '{1'b1, 8'h44, 1'b1, 1'b1, 8'h44, 1'b1, 2'd3, 4'd1};
        tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 4'd0};
        tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 4'd0};

        rst_n = 1'b0; psum_in_vld = 1'b0; psum_in = '0; m_ready = 1'b0;
        do_reset();
        chk_en = 1'b1;
        check("rst_valid", 32'(m_valid), 32'd0);
        check("rst_last", 32'(m_last), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_stall", 32'(mac_read_stall), 32'd0);

        // Single burst
        for (int i = 0; i < 6; i++) begin
            step(tbl[i].vld, tbl[i].data, tbl[i].rdy);
            check("burst_valid", 32'(m_valid), 32'(tbl[i].e_valid));
            if (tbl[i].e_valid) check("burst_data", 32'(m_data), 32'(tbl[i].e_data));
            check("burst_last", 32'(m_last), 32'(tbl[i].e_last));
            check("burst_idx", 32'(m_idx), 32'(tbl[i].e_idx));
            check("burst_count", 32'(count), 32'(tbl[i].e_count));
        end

        // Fill then drain
        do_reset();
        v = 1; acc = 0;
        for (int c = 0; c < 12; c++) begin
            take = !mac_read_stall;
            step(1'b1, 8'(v), 1'b0);
            if (take) begin v++; acc++; end
        end
        check("fill_accepted", acc, 32'd7);
        check("fill_count", 32'(count), 32'd7);
        check("fill_stall", 32'(mac_read_stall), 32'd1);
        got.delete();
        for (int c = 0; c < 60; c++) begin
            take = !mac_read_stall && (v <= 10);
            if (m_valid) got.push_back(m_data);
            step(v <= 10, 8'(v), 1'b1);
            if (take) v++;
            if (c == 0) begin
                check("drain_count", 32'(count), 32'd6);
                check("drain_stall", 32'(mac_read_stall), 32'd0);
            end
            if (v > 10 && count == 4'd0) break;
        end
        check("drain_size", got.size(), 32'd10);
        for (int i = 0; i < got.size(); i++) check("drain_order", 32'(got[i]), i + 1);

        // Simultaneous push and pop at count 6
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b1, 8'(8'hC0 + i), 1'b0);
        check("sim_pre_count", 32'(count), 32'd6);
        check("sim_head", 32'(m_data), 32'h0C0);
        step(1'b1, 8'hAB, 1'b1);
        check("sim_count", 32'(count), 32'd6);
        check("sim_stall", 32'(mac_read_stall), 32'd0);
        check("sim_newhead", 32'(m_data), 32'h0C1);

        // Reset mid-burst
        do_reset();
        step(1'b1, 8'h01, 1'b1);
        step(1'b1, 8'h02, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        check("mid_idx", 32'(m_idx), 32'd2);
        step(1'b1, 8'h03, 1'b0);
        step(1'b1, 8'h04, 1'b0);
        step(1'b1, 8'h05, 1'b0);
        check("mid_count", 32'(count), 32'd3);
        rst_n = 1'b0;
        step(1'b1, 8'h99, 1'b0);
        rst_n = 1'b1;
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_valid", 32'(m_valid), 32'd0);
        check("mid_rst_last", 32'(m_last), 32'd0);
        step(1'b1, 8'h5A, 1'b1);
        check("mid_5a_valid", 32'(m_valid), 32'd1);
        check("mid_5a_data", 32'(m_data), 32'h05A);
        check("mid_5a_idx", 32'(m_idx), 32'd0);
        step(1'b0, 8'h00, 1'b1);
        check("mid_5a_popped", 32'(count), 32'd0);

        // Held input while stalled
        do_reset();
        for (int i = 0; i < 7; i++) step(1'b1, 8'(8'h30 + i), 1'b0);
        check("stl_stall", 32'(mac_read_stall), 32'd1);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 8'h77, 1'b0);
            check("stl_hold_count", 32'(count), 32'd7);
        end
        step(1'b1, 8'h77, 1'b1);
        check("stl_pop_count", 32'(count), 32'd6);
        step(1'b1, 8'h77, 1'b0);
        check("stl_write_count", 32'(count), 32'd7);
        step(1'b1, 8'h77, 1'b0);
        step(1'b1, 8'h77, 1'b0);
        check("stl_rehold_count", 32'(count), 32'd7);
        got.delete();
        for (int c = 0; c < 10; c++) begin
            if (m_valid) got.push_back(m_data);
            step(1'b0, 8'h00, 1'b1);
        end
        n77 = 0;
        foreach (got[i]) if (got[i] == 8'h77) n77++;
        check("stl_drain_size", got.size(), 32'd7);
        check("stl_77_once", n77, 32'd1);

        // Wrap with random backpressure
        do_reset();
        foreach (words[i]) words[i] = 8'($urandom);
        got.delete();
        sent = 0; pops = 0; done = 1'b0;
        for (int c = 0; c < 400; c++) begin
            vb = (sent < 20) && ($urandom_range(0, 3) != 0);
            rb = 1'($urandom_range(0, 1));
            take = vb && !mac_read_stall;
            if (m_valid && rb) begin
                got.push_back(m_data);
                pops++;
                check("wrap_last", 32'(m_last), 32'(pops % 4 == 0));
            end
            step(vb, (sent < 20) ? words[sent] : 8'h00, rb);
            if (take) sent++;
            if (sent == 20 && count == 4'd0) begin done = 1'b1; break; end
        end
        check("wrap_done", 32'(done), 32'd1);
        check("wrap_size", got.size(), 32'd20);
        for (int i = 0; i < got.size() && i < 20; i++) check("wrap_order", 32'(got[i]), 32'(words[i]));

        // Random soak against the model, with occasional resets
        for (int c = 0; c < 400; c++) begin
            rst_n = ($urandom_range(0, 49) != 0);
            step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 2) != 0));
        end
        rst_n = 1'b1;

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/psum_collector.md
PSUM_COLLECTOR -- requirements
Module: psum_collector

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of each partial-sum word.
REQ-002 Parameter ROWS, default 4: number of psum beats per column burst; sets the m_last period; at least 2.
REQ-003 Parameter FIFO_DEPTH, default 8: buffer entries; power of 2, at least 4.
REQ-004 Port clk, input, 1: the single clock; all logic on its rising edge.
REQ-005 Port rst_n, input, 1: reset; synchronous, active-low.
REQ-006 Port psum_in, input, DATA_WIDTH: psum word from the bottom MAC of a column.
REQ-007 Port psum_in_vld, input, 1: psum_in is valid this cycle.
REQ-008 Port mac_read_stall, output, 1: registered backpressure to the MAC chain; high means the MAC holds its output.
REQ-009 Port m_data, output, DATA_WIDTH: output stream data.
REQ-010 Port m_valid, output, 1: output stream valid.
REQ-011 Port m_ready, input, 1: downstream ready.
REQ-012 Port m_last, output, 1: m_data is the final beat of a ROWS-beat burst.
REQ-013 Port m_idx, output, $clog2(ROWS): index of the m_data beat within its burst.
REQ-014 Port count, output, $clog2(FIFO_DEPTH)+1: current FIFO occupancy.

Function
REQ-015 The block SHALL accept an input word in cycle t only when psum_in_vld=1 and mac_read_stall=0 in cycle t; a held word during stall SHALL NOT be written twice.
REQ-016 The output SHALL be first-word-fall-through: m_valid=(count!=0); m_data is the oldest entry, driven combinationally from the memory.
REQ-017 A word accepted in cycle t SHALL appear on m_data with m_valid=1 in cycle t+1 if the FIFO was empty.
REQ-018 A pop SHALL occur when m_valid=1 and m_ready=1; m_data, m_last and m_idx SHALL hold stable while m_valid=1 and m_ready=0.
REQ-019 With a simultaneous push and pop, count SHALL remain unchanged and order SHALL be preserved.
REQ-020 Read and write pointers SHALL be $clog2(FIFO_DEPTH) bits wide and wrap modulo FIFO_DEPTH.
REQ-021 count_next SHALL equal count+push-pop; mac_read_stall SHALL be registered as (count_next >= FIFO_DEPTH-1).
REQ-022 By construction count SHALL NOT exceed FIFO_DEPTH-1; a push with count=FIFO_DEPTH is unreachable, and the bench SHALL assert this.
REQ-023 A beat counter SHALL increment on each pop and wrap from ROWS-1 to 0.
REQ-024 m_idx SHALL equal the beat counter; m_last SHALL equal m_valid && (beat counter == ROWS-1).
REQ-025 psum_in_vld=0 SHALL neither write nor modify any state except through a pop.
REQ-026 psum_in data SHALL pass through unmodified; no arithmetic or truncation.

Reset
REQ-027 When rst_n=0 at a rising edge, count, both pointers and the beat counter SHALL clear to 0, and mac_read_stall SHALL clear to 0.
REQ-028 During and after reset, m_valid=0 and m_last=0; FIFO memory contents need not be cleared.
REQ-029 Reset asserted mid-burst SHALL discard all buffered words; the first post-reset pop SHALL carry m_idx=0.
REQ-030 Inputs presented in a cycle with rst_n=0 SHALL NOT be accepted.

Verification (DATA_WIDTH=8, ROWS=4, FIFO_DEPTH=8)
REQ-031 Single burst test: m_ready=1; push 0x11, 0x22, 0x33, 0x44 in consecutive cycles.
- Each word SHALL appear one cycle after acceptance.
- m_idx SHALL step 0, 1, 2, 3.
- m_last=1 only with 0x44.
REQ-032 Fill test: m_ready=0; hold psum_in_vld=1 with values 0x01..0x0A, advancing only on acceptance.
- Exactly 7 words SHALL be accepted; count=7 and mac_read_stall=1 from the following cycle.
- Raising m_ready SHALL drain 0x01..0x07 in order; stall SHALL drop once count_next<7; 0x08..0x0A SHALL follow with none lost or duplicated.
REQ-033 Simultaneous push/pop test: count=6, push 0xAB with m_ready=1 -> count stays 6, mac_read_stall stays 0, the head word pops.
REQ-034 Reset mid-burst test: pop 2 beats, then push 3 words without popping, then pulse rst_n=0 for one cycle.
- Result: count=0, m_valid=0.
- The next push of 0x5A SHALL pop with m_idx=0.
REQ-035 Stalled-input test: keep mac_read_stall=1 by holding m_ready=0, with psum_in_vld=1 and psum_in=0x77 for 5 cycles -> no writes; after one pop, 0x77 SHALL be written exactly once.
REQ-036 Wrap test: stream 20 words with random m_ready, 50% duty.
- Output order SHALL equal input order across pointer wrap.
- m_last SHALL occur every 4th pop.
